// File: rtl/bitblaster_pkg.sv
// rtl/bitblaster_pkg.sv - shared FN/opcode constants, FSM state type and instruction decode
package bitblaster_pkg;

  localparam logic [3:0] FN_LOAD = 4'b0000;
  localparam logic [3:0] FN_COPY = 4'b0001;
  localparam logic [3:0] FN_ADD  = 4'b0010;
  localparam logic [3:0] FN_SUB  = 4'b0011;
  localparam logic [3:0] FN_INV  = 4'b0100;
  localparam logic [3:0] FN_FLP  = 4'b0101;
  localparam logic [3:0] FN_AND  = 4'b0110;
  localparam logic [3:0] FN_OR   = 4'b0111;
  localparam logic [3:0] FN_XOR  = 4'b1000;
  localparam logic [3:0] FN_LSL  = 4'b1001;
  localparam logic [3:0] FN_LSR  = 4'b1010;
  localparam logic [3:0] FN_ASR  = 4'b1011;
  localparam logic [3:0] FN_ADDI = 4'b1100;
  localparam logic [3:0] FN_SUBI = 4'b1101;

  localparam logic [1:0] OP_REG  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_SUBI = 2'b11;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  typedef enum logic [2:0] {CL_LD, CL_CP, CL_ILL, CL_ALU, CL_IMM, CL_INV, CL_FLP} iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [3:0] fn;
  } decode_t;

  // Illegal words decode to FN 0000 so FN stays quiet during their single step.
  function automatic decode_t decode(input logic [9:0] ir);
    decode_t d;
    d.cls = CL_ILL;
    d.fn  = FN_LOAD;
    case (ir[9:8])
      OP_REG: begin
        if (ir[3:0] < FN_ADDI) begin
          d.fn = ir[3:0];
          case (ir[3:0])
            FN_LOAD: d.cls = CL_LD;
            FN_COPY: d.cls = CL_CP;
            FN_INV:  d.cls = CL_INV;
            FN_FLP:  d.cls = CL_FLP;
            default: d.cls = CL_ALU;
          endcase
        end
      end
      OP_ADDI: begin
        d.cls = CL_IMM;
        d.fn  = FN_ADDI;
      end
      OP_SUBI: begin
        d.cls = CL_IMM;
        d.fn  = FN_SUBI;
      end
      default: d.cls = CL_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// rtl/control_fsm_if.sv - instruction/handshake and datapath control bundle
interface control_fsm_if #(parameter int NREG = 4);
  logic [9:0]      INSTR;
  logic            Exec;
  logic            IRin;
  logic [9:0]      IR;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            ExtOut;
  logic            ImmOut;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic [3:0]      FN;
  logic            Busy;
  logic            Done;

  modport master (
    output INSTR, Exec,
    input  IRin, IR, Rin, Rout, ExtOut, ImmOut, Ain, Gin, Gout, FN, Busy, Done
  );

  modport slave (
    input  INSTR, Exec,
    output IRin, IR, Rin, Rout, ExtOut, ImmOut, Ain, Gin, Gout, FN, Busy, Done
  );
endinterface

// File: rtl/dec2to4.sv
// rtl/dec2to4.sv - 2-bit select to one-hot decoder with enable
module dec2to4 #(
  parameter int N = 4
) (
  input  logic         en_i,
  input  logic [1:0]   sel_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o = {{(N-1){1'b0}}, 1'b1} << sel_i;
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle instruction sequencer driving register file and ALU controls
module control_fsm
  import bitblaster_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic          CLKb,
  input  logic          RSTb,
  control_fsm_if.slave  bus
);

  state_t     state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic       armed_q, armed_d;
  decode_t    dec;
  logic       load;

  logic       rin_en, rout_en;
  logic [1:0] rin_sel, rout_sel;
  logic       ext_out, imm_out, ain, gin, gout, done;

  assign dec  = decode(ir_q);
  assign load = (state_q == IDLE) && bus.Exec && armed_q;

  // armed re-arms only on an edge that sees Exec low, so a held Exec cannot re-trigger.
  always_comb begin
    ir_d    = load ? bus.INSTR : ir_q;
    armed_d = armed_q;
    if (load)           armed_d = 1'b0;
    else if (!bus.Exec) armed_d = 1'b1;
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      ir_q    <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rin_sel  = ir_q[7:6];
    rout_sel = ir_q[7:6];
    ext_out  = 1'b0;
    imm_out  = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: if (load) state_d = T1;
      T1: begin
        state_d = T2;
        case (dec.cls)
          CL_LD: begin
            ext_out = 1'b1;
            rin_en  = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
          end
          CL_CP: begin
            rout_en  = 1'b1;
            rout_sel = ir_q[5:4];
            rin_en   = 1'b1;
            done     = 1'b1;
            state_d  = IDLE;
          end
          CL_ILL: begin
            done    = 1'b1;
            state_d = IDLE;
          end
          CL_INV: ;
          CL_FLP: begin
            rout_en  = 1'b1;
            rout_sel = ir_q[5:4];
            ain      = 1'b1;
          end
          default: begin
            rout_en = 1'b1;
            ain     = 1'b1;
          end
        endcase
      end
      T2: begin
        state_d  = T3;
        gin      = 1'b1;
        rout_sel = ir_q[5:4];
        // flp operates on A alone, so nothing drives the bus in this step.
        case (dec.cls)
          CL_IMM:  imm_out = 1'b1;
          CL_FLP:  ;
          default: rout_en = 1'b1;
        endcase
      end
      T3: begin
        state_d = IDLE;
        gout    = 1'b1;
        rin_en  = 1'b1;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  dec2to4 #(.N(NREG)) u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (rin_sel),
    .onehot_o (bus.Rin)
  );

  dec2to4 #(.N(NREG)) u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (bus.Rout)
  );

  assign bus.IRin   = load && RSTb;
  assign bus.IR     = ir_q;
  assign bus.ExtOut = ext_out;
  assign bus.ImmOut = imm_out;
  assign bus.Ain    = ain;
  assign bus.Gin    = gin;
  assign bus.Gout   = gout;
  assign bus.Done   = done;
  assign bus.Busy   = (state_q != IDLE);
  assign bus.FN     = (state_q != IDLE) ? dec.fn : 4'b0000;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard bench for control_fsm
module tb_control_fsm;

  typedef struct packed {
    logic [3:0] rin;
    logic [3:0] rout;
    logic       ext, imm, ain, gin, gout;
    logic [3:0] fn;
    logic       done;
    logic [9:0] ir;
    logic [9:0] busv;
  } step_t;

  logic CLKb = 1'b1;
  logic RSTb = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  step_t exp_q[$];

  control_fsm_if #(.NREG(4)) bus ();

  control_fsm #(.NREG(4)) dut (
    .CLKb (CLKb),
    .RSTb (RSTb),
    .bus  (bus)
  );

  always #5 CLKb = ~CLKb;

  function automatic step_t mk(input logic [3:0] rin, input logic [3:0] rout,
                               input logic ext, input logic imm, input logic ain,
                               input logic gin, input logic gout, input logic [3:0] fn,
                               input logic done, input logic [9:0] ir, input logic [9:0] busv);
    step_t s;
    s = '{rin, rout, ext, imm, ain, gin, gout, fn, done, ir, busv};
    return s;
  endfunction

  function automatic step_t sample();
    step_t s;
    s.rin  = bus.Rin;
    s.rout = bus.Rout;
    s.ext  = bus.ExtOut;
    s.imm  = bus.ImmOut;
    s.ain  = bus.Ain;
    s.gin  = bus.Gin;
    s.gout = bus.Gout;
    s.fn   = bus.FN;
    s.done = bus.Done;
    s.ir   = bus.IR;
    s.busv = bus.ExtOut ? bus.INSTR : (bus.ImmOut ? {4'b0000, bus.IR[5:0]} : 10'h000);
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every busy step consumes one expected record; idle steps must be silent.
  always @(posedge CLKb) begin
    step_t a;
    a = sample();
    if (bus.Busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_step: got %h expected no busy step", a);
      end else begin
        chk("step", 64'(a), 64'(exp_q.pop_front()));
      end
    end else if (RSTb) begin
      a.ir   = '0;
      a.busv = '0;
      chk("idle_quiet", 64'(a), 64'h0);
    end
  end

  task automatic run_instr(input string name, input logic [9:0] instr,
                           input logic [9:0] data, input int steps);
    int cnt;
    bus.INSTR = instr;
    bus.Exec  = 1'b1;
    #1 chk({name, "_irin"}, 64'(bus.IRin), 64'h1);
    @(negedge CLKb);
    #1;
    bus.Exec  = 1'b0;
    bus.INSTR = data;
    @(posedge CLKb);
    #2;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (!bus.Busy) break;
      cnt++;
      @(posedge CLKb);
      #2;
    end
    chk({name, "_steps"}, 64'(cnt), 64'(steps));
  endtask

  task automatic push_add();
    exp_q.push_back(mk(4'b0000, 4'b0001, 0, 0, 1, 0, 0, 4'b0010, 0, 10'h032, 10'h000));
    exp_q.push_back(mk(4'b0000, 4'b1000, 0, 0, 0, 1, 0, 4'b0010, 0, 10'h032, 10'h000));
    exp_q.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 0, 1, 4'b0010, 1, 10'h032, 10'h000));
  endtask

  initial begin
    bus.INSTR = 10'h000;
    bus.Exec  = 1'b0;
    repeat (2) @(posedge CLKb);
    #1 chk("reset_outputs",
           64'({bus.Rin, bus.Rout, bus.ExtOut, bus.ImmOut, bus.Ain, bus.Gin, bus.Gout,
                bus.FN, bus.Done, bus.Busy, bus.IRin, bus.IR}), 64'h0);
    #1 RSTb = 1'b1;

    // add R0,R3 interrupted by reset during T2
    @(posedge CLKb);
    #2;
    exp_q.push_back(mk(4'b0000, 4'b0001, 0, 0, 1, 0, 0, 4'b0010, 0, 10'h032, 10'h000));
    exp_q.push_back(mk(4'b0000, 4'b1000, 0, 0, 0, 1, 0, 4'b0010, 0, 10'h032, 10'h000));
    bus.INSTR = 10'h032;
    bus.Exec  = 1'b1;
    @(negedge CLKb);
    #1 bus.Exec = 1'b0;
    @(posedge CLKb);
    @(negedge CLKb);
    @(posedge CLKb);
    #2 RSTb = 1'b0;
    #1 chk("reset_midop",
           64'({bus.Rin, bus.Rout, bus.ExtOut, bus.ImmOut, bus.Ain, bus.Gin, bus.Gout,
                bus.FN, bus.Done, bus.Busy, bus.IR}), 64'h0);
    @(posedge CLKb);
    #2 RSTb = 1'b1;

    exp_q.push_back(mk(4'b0010, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 10'h040, 10'h155));
    run_instr("ld_155", 10'h040, 10'h155, 1);
    exp_q.push_back(mk(4'b0010, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 10'h040, 10'h0AA));
    run_instr("ld_0aa", 10'h040, 10'h0AA, 1);
    exp_q.push_back(mk(4'b0100, 4'b0010, 0, 0, 0, 0, 0, 4'b0001, 1, 10'h091, 10'h000));
    run_instr("cp", 10'h091, 10'h3FF, 1);
    push_add();
    run_instr("add", 10'h032, 10'h3FF, 3);

    exp_q.push_back(mk(4'b0000, 4'b0100, 0, 0, 1, 0, 0, 4'b1100, 0, 10'h2BF, 10'h000));
    exp_q.push_back(mk(4'b0000, 4'b0000, 0, 1, 0, 1, 0, 4'b1100, 0, 10'h2BF, 10'h03F));
    exp_q.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 0, 1, 4'b1100, 1, 10'h2BF, 10'h000));
    run_instr("addi", 10'h2BF, 10'h000, 3);

    exp_q.push_back(mk(4'b0000, 4'b0010, 0, 0, 1, 0, 0, 4'b1101, 0, 10'h345, 10'h000));
    exp_q.push_back(mk(4'b0000, 4'b0000, 0, 1, 0, 1, 0, 4'b1101, 0, 10'h345, 10'h005));
    exp_q.push_back(mk(4'b0010, 4'b0000, 0, 0, 0, 0, 1, 4'b1101, 1, 10'h345, 10'h000));
    run_instr("subi", 10'h345, 10'h000, 3);

    exp_q.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 0, 10'h0D4, 10'h000));
    exp_q.push_back(mk(4'b0000, 4'b0010, 0, 0, 0, 1, 0, 4'b0100, 0, 10'h0D4, 10'h000));
    exp_q.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 0, 1, 4'b0100, 1, 10'h0D4, 10'h000));
    run_instr("inv", 10'h0D4, 10'h000, 3);

    exp_q.push_back(mk(4'b0000, 4'b0100, 0, 0, 1, 0, 0, 4'b0101, 0, 10'h025, 10'h000));
    exp_q.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 1, 0, 4'b0101, 0, 10'h025, 10'h000));
    exp_q.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 0, 1, 4'b0101, 1, 10'h025, 10'h000));
    run_instr("flp", 10'h025, 10'h000, 3);

    exp_q.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 10'h1B3, 10'h000));
    run_instr("ill_op01", 10'h1B3, 10'h000, 1);
    exp_q.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 10'h00E, 10'h000));
    run_instr("ill_fn1110", 10'h00E, 10'h000, 1);

    // Exec held high for three instruction periods, INSTR changed while busy
    push_add();
    bus.INSTR = 10'h032;
    bus.Exec  = 1'b1;
    @(negedge CLKb);
    @(posedge CLKb);
    #2 bus.INSTR = 10'h3FF;
    repeat (12) @(posedge CLKb);
    #2;
    chk("held_idle", 64'(bus.Busy), 64'h0);
    chk("held_no_irin", 64'(bus.IRin), 64'h0);
    bus.Exec = 1'b0;
    @(negedge CLKb);
    @(posedge CLKb);
    #2;
    exp_q.push_back(mk(4'b0100, 4'b0010, 0, 0, 0, 0, 0, 4'b0001, 1, 10'h091, 10'h000));
    run_instr("rearm_cp", 10'h091, 10'h000, 1);

    // Exec rising during T3 is accepted one edge after the return to IDLE
    push_add();
    bus.INSTR = 10'h032;
    bus.Exec  = 1'b1;
    @(negedge CLKb);
    @(posedge CLKb);
    #2 bus.Exec = 1'b0;
    @(posedge CLKb);
    #2;
    @(posedge CLKb);
    #2;
    exp_q.push_back(mk(4'b0100, 4'b0010, 0, 0, 0, 0, 0, 4'b0001, 1, 10'h091, 10'h000));
    bus.INSTR = 10'h091;
    bus.Exec  = 1'b1;
    #1 chk("t3_irin_busy", 64'(bus.IRin), 64'h0);
    @(negedge CLKb);
    @(posedge CLKb);
    #2;
    chk("t3_not_taken", 64'(bus.Busy), 64'h0);
    chk("t3_irin_next", 64'(bus.IRin), 64'h1);
    @(negedge CLKb);
    @(posedge CLKb);
    #2 bus.Exec = 1'b0;
    chk("late_cp_busy", 64'(bus.Busy), 64'h1);
    @(posedge CLKb);
    #2 chk("late_cp_done", 64'(bus.Busy), 64'h0);

    @(posedge CLKb);
    #2 chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
